// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: FSM encoding,
// reset PC default, instruction field positions and the IF/ID payload type.
package fetch_stage_pkg;

  typedef enum logic {
    FETCH = 1'b0,   // read request outstanding at pc
    HOLD  = 1'b1    // skid full, no request issued
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  // Payload carried by both the IF/ID register and the skid buffer
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_entry_t;

  // Instruction addresses are always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer: parks a returned word when decode is stalled and
// IF/ID is already occupied. Clear wins over load, load wins over pop.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        pop_i,
  input  ifid_entry_t entry_i,
  output logic        valid_o,
  output ifid_entry_t entry_o
);

  logic        valid_q, valid_d;
  ifid_entry_t entry_q, entry_d;

  // Next-state: occupancy and captured payload
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers, synchronous reset to empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the pc, issues instruction-memory reads,
// fills the IF/ID register and absorbs one in-flight word in a skid buffer
// when decode stalls. Redirect beats flush beats normal flow.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_read_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc4_o,
  output logic [5:0]  if_op_o,
  output logic [5:0]  if_fn_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         ifv_q, ifv_d;
  ifid_entry_t  ifid_q, ifid_d;

  logic         skid_clear, skid_load, skid_pop, skid_valid;
  ifid_entry_t  skid_entry;
  ifid_entry_t  fetched;
  logic [31:0]  pc_plus4;

  // pc+4 wraps naturally in 32 bits
  assign pc_plus4 = pc_q + 32'd4;
  assign fetched  = '{instr: imem_data_i, pc4: pc_plus4};

  fetch_skid u_skid (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clear_i (skid_clear),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .entry_i (fetched),
    .valid_o (skid_valid),
    .entry_o (skid_entry)
  );

  // Next-state, pc and IF/ID update; skid controls
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifv_d      = ifv_q;
    ifid_d     = ifid_q;
    skid_clear = 1'b0;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;

    if (redirect_i) begin
      // Any word returned this cycle belongs to the wrong path: drop it
      pc_d       = word_align(redirect_pc_i);
      ifv_d      = 1'b0;
      skid_clear = 1'b1;
      state_d    = FETCH;
    end else if (flush_i) begin
      // pc is already past the dropped words, so it is left alone
      ifv_d      = 1'b0;
      skid_clear = 1'b1;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready_i) begin
            pc_d = pc_plus4;
            if (!ifv_q || !stall_i) begin
              ifv_d  = 1'b1;
              ifid_d = fetched;
            end else begin
              // Decode is holding a live instruction: park the new word
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end else if (!stall_i) begin
            // Decode consumed IF/ID and nothing arrived to replace it
            ifv_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifv_d    = skid_valid;
            ifid_d   = skid_entry;
            skid_pop = 1'b1;
            state_d  = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Stage registers, synchronous reset overrides every other control
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ifv_q   <= 1'b0;
      ifid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifv_q   <= ifv_d;
      ifid_q  <= ifid_d;
    end
  end

  // pc only moves on a completed fetch, so the address is stable while waiting
  assign imem_read_o = (state_q == FETCH);
  assign imem_addr_o = pc_q;

  assign if_valid_o = ifv_q;
  assign if_instr_o = ifv_q ? ifid_q.instr : 32'h0;
  assign if_pc4_o   = ifid_q.pc4;
  assign if_op_o    = if_instr_o[OP_MSB:OP_LSB];
  assign if_fn_o    = if_instr_o[FN_MSB:FN_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The reference model views the stage as
// an instruction queue of depth two (IF/ID + skid): a request is issued only
// while fewer than two words are held, decode removes the head when not
// stalled, and flush/redirect/reset empty the queue.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_i = 1'b1;
  logic        stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_read_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        if_valid_o;
  logic [31:0] if_instr_o, if_pc4_o;
  logic [5:0]  if_op_o, if_fn_o;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clock_i(clock), .reset_i(reset_i), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_read_o(imem_read_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_data_i(imem_data_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc4_o(if_pc4_o),
    .if_op_o(if_op_o), .if_fn_o(if_fn_o)
  );

  always #5 clock = ~clock;

  int   errs = 0, checks = 0;
  exp_t exp_q[$];
  int   cnt = 0;          // words held by the stage per the model
  logic [31:0] mpc = '0;  // model fetch pc
  bit   chk_en = 0, just_reset = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock cycle: check state left by the last edge, then drive the next
  task automatic cyc(input bit rs, input bit st, input bit fl, input bit rd,
                     input logic [31:0] rpc, input bit rdy);
    bit fetch, cons;
    @(posedge clock); #2;
    if (chk_en) begin
      chk("imem_read", {31'b0, imem_read_o}, {31'b0, cnt < 2});
      if (cnt < 2) chk("imem_addr", imem_addr_o, mpc);
      chk("if_valid", {31'b0, if_valid_o}, {31'b0, cnt > 0});
      if (cnt == 0) chk("if_instr_zero", if_instr_o, 32'h0);
      if (cnt > 0 && exp_q.size() > 0) begin
        chk("if_instr_hold", if_instr_o, exp_q[0].instr);
        chk("if_pc4_hold", if_pc4_o, exp_q[0].pc4);
      end
      if (just_reset) chk("reset_pc4", if_pc4_o, 32'h0);
    end
    just_reset    = rs;
    reset_i       = rs;
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_ready_i  = rdy;
    imem_data_i   = mem_word(imem_addr_o);
    if (rs) begin
      exp_q.delete(); cnt = 0; mpc = RST_PC; chk_en = 1;
    end else if (rd) begin
      exp_q.delete(); cnt = 0; mpc = rpc & 32'hFFFF_FFFC;
    end else if (fl) begin
      exp_q.delete(); cnt = 0;
    end else begin
      fetch = (cnt < 2) && rdy;
      cons  = (cnt > 0) && !st;
      if (fetch) begin
        exp_q.push_back('{instr: mem_word(mpc), pc4: mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
      cnt = cnt - int'(cons) + int'(fetch);
    end
  endtask

  // Monitor: every instruction decode accepts must match the scoreboard head
  always @(negedge clock) begin
    exp_t e;
    if (chk_en && !reset_i && !flush_i && !redirect_i && !stall_i && if_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++; errs++;
        $display("FAIL accept_unexpected: got instr %h pc4 %h want none", if_instr_o, if_pc4_o);
      end else begin
        e = exp_q.pop_front();
        chk("accept_instr", if_instr_o, e.instr);
        chk("accept_pc4", if_pc4_o, e.pc4);
        chk("accept_op", {26'b0, if_op_o}, {26'b0, e.instr[31:26]});
        chk("accept_fn", {26'b0, if_fn_o}, {26'b0, e.instr[5:0]});
      end
    end
  end

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 32'h44, 1);
    // Streaming fetch from 0
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    // Stall across a completing fetch: skid fills, HOLD, then drains
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Redirect concurrent with a returned word
    cyc(0, 0, 0, 1, 32'h0000_0043, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // Flush while in HOLD
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // pc wrap
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // Memory wait, then reset with the access outstanding
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'h100, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 99) < 40,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 5,
          rpc,
          $urandom_range(0, 99) < 60);
    end
    // Drain
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    @(posedge clock); #2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
